dvs_aer_to_event_iface: RTL and testbench
=========================================

# dvs_aer_to_event_iface

Receiver-side bridge between a DVS camera's asynchronous AER (Address-Event Representation) bus and the on-chip event FIFO. It performs the 4-phase REQ/ACK handshake with the camera and collects the row (Y) and column (X) address words. For every X word it writes one packed event word to the FIFO through an arbitrated request/grant port. The block sits between the camera pads and the shared FIFO bus arbiter.

## Interface
- `X_BITS`, 9: column address width.
- `Y_BITS`, 9: row address width.
- `EVENT_BITS`, 19: must equal `X_BITS+Y_BITS+1`.
- `CLK_PERIOD_NS`, 10: clock period, used only to derive the settle count.
- `Y_SETTLE_NS`, 50: minimum time from REQ assertion to ACK for a Y word.
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `aer`  in  10: asynchronous AER data. X word: `[9:1]`=X, `[0]`=polarity. Y word: `[8:0]`=Y, `[9]` is don't-care.
- `xsel`  in  1: asynchronous word type; 1 = X word, 0 = Y word.
- `req`  in  1: asynchronous camera request.
- `fifo_grant`  in  1: arbiter grant; held high until `fifo_req` falls.
- `ack`  out  1: AER acknowledge, registered.
- `fifo_req`  out  1: FIFO bus request.
- `fifo_wr_en`  out  1: single-cycle FIFO write strobe.
- `fifo_event`  out  EVENT_BITS: `{x[8:0], y[8:0], polarity}`, with X in the MSBs.

## Operation
- `req` passes through a 2-flop synchronizer (`req_s`). `aer` and `xsel` are sampled only when the FSM latches; they are stable by protocol at that point.
- AER FSM states:
  - IDLE: when `req_s`=1, go to SETTLE.
  - SETTLE: count `Y_SETTLE_CYC = ceil(Y_SETTLE_NS/CLK_PERIOD_NS)` cycles (5 at the defaults), then go to LATCH. The count applies to both X and Y words.
  - LATCH, Y word: store `aer[8:0]` in the row register and go to ACK.
  - LATCH, X word: go to ACK only if no write is pending. Store `aer[9:1]` and `aer[0]` into a pending event built with the current row register, and set `pend`.
  - ACK: `ack`=1; when `req_s`=0, go to IDLE with `ack`=0.
- The row register persists across events. Consecutive X words without an intervening Y reuse the last Y. The row register resets to 0.
- FIFO path:
  - While `pend`=1, `fifo_req`=1.
  - In the first cycle `fifo_grant`=1 is sampled, assert `fifo_wr_en` for exactly one cycle and drive `fifo_event` with the pending word.
  - The next cycle: `fifo_req`=0 and `pend`=0.
  - `fifo_event` holds its last written value otherwise.
- Exactly one FIFO write per X word, and none per Y word.

## Timing
- Reset value of every output and register: `ack`=0, `fifo_req`=0, `fifo_wr_en`=0, `fifo_event`=0. FSM goes to IDLE, `pend`=0, row register = 0.
- Reset asserted mid-handshake: `ack` drops in the next cycle and any pending event is discarded. After reset, if `req` is still high, a fresh handshake starts from IDLE.
- Latency from `req` rising to `ack` rising: 2 sync cycles + `Y_SETTLE_CYC` + 1 cycle (8 cycles at the defaults). This is always ≥ 50 ns.
- Latency from `req` falling to `ack` falling: 2–3 cycles.
- `fifo_req` rises the cycle after the X latch. `fifo_wr_en` is never asserted while `fifo_grant`=0.
- A new X word arriving while `pend`=1 is held in LATCH, with `ack` withheld, until the write completes. No event is ever dropped.
- `fifo_grant` rising in the same cycle `fifo_req` rises counts as a grant.

## Configuration
- `DVS_AER_SYNC3_EN`:
  - Defined: `req` uses a 3-flop synchronizer. Every `req`-related latency grows by 1 cycle.
  - Undefined: 2-flop synchronizer as specified above.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `req`=1 -> `ack`, `fifo_req`, `fifo_wr_en` and `fifo_event` are all 0. After release, `ack` rises 8 cycles later.
- Y then X: Y=0x05A with `aer[9]`=1, then X=0x123 with polarity 1, grant given immediately -> one `fifo_wr_en` pulse with `fifo_event`=`{9'h123, 9'h05A, 1'b1}`. Y `ack` rises ≥ 50 ns after `req`.
- Repeated row: Y=0x010, then X=0x001 and X=0x002 with no new Y -> two writes, both with y=0x010.
- Grant delay: withhold `fifo_grant` for 5 cycles -> `fifo_req` stays high and `fifo_wr_en` is exactly one cycle after grant. A second X word during the wait has its `ack` held off until the write completes.
- Slow `req` release: camera keeps `req` high 20 cycles after `ack` -> `ack` stays high and falls 2–3 cycles after `req` falls. No second latch occurs.
- Randomized stream at ≤ 12 MHz event rate with random grant delays -> the FIFO write count equals the X word count, and every event carries the most recent Y.

Source files
------------

// File: rtl/dvs_aer_to_event_iface_if.sv
// -----------------------------------------------------------------------------
// dvs_aer_to_event_iface_if
//
// This interface bundles the signals between the AER-to-event bridge and its
// environment. The environment is the DVS camera pads plus the shared FIFO
// bus arbiter.
//
//   aer        camera -> bridge   AER data word. The X word is
//                                 {x[X_BITS-1:0], polarity}. The Y word carries
//                                 y in the low Y_BITS bits.
//   xsel       camera -> bridge   word type: 1 = X word, 0 = Y word
//   req        camera -> bridge   asynchronous 4-phase request
//   ack        bridge -> camera   registered 4-phase acknowledge
//   fifo_req   bridge -> arbiter  FIFO bus request, held while a write is pending
//   fifo_grant arbiter -> bridge  grant, held until fifo_req falls
//   fifo_wr_en bridge -> FIFO     single-cycle write strobe
//   fifo_event bridge -> FIFO     {x, y, polarity}, with X in the MSBs
//
// Modports:
//   master - the environment side (camera and arbiter)
//   slave  - the bridge side
// -----------------------------------------------------------------------------
interface dvs_aer_to_event_iface_if #(
    parameter int X_BITS     = 9,
    parameter int Y_BITS     = 9,
    parameter int EVENT_BITS = 19
);
    logic [X_BITS:0]       aer;
    logic                  xsel;
    logic                  req;
    logic                  ack;
    logic                  fifo_grant;
    logic                  fifo_req;
    logic                  fifo_wr_en;
    logic [EVENT_BITS-1:0] fifo_event;

    modport master (
        output aer, xsel, req, fifo_grant,
        input  ack, fifo_req, fifo_wr_en, fifo_event
    );

    modport slave (
        input  aer, xsel, req, fifo_grant,
        output ack, fifo_req, fifo_wr_en, fifo_event
    );
endinterface

// File: rtl/dvs_aer_to_event_iface.sv
// -----------------------------------------------------------------------------
// dvs_aer_to_event_iface
//
// This is the receiver-side bridge from a DVS camera's asynchronous AER bus to
// the on-chip event FIFO. It does the following:
//   - runs the 4-phase REQ/ACK handshake with the camera;
//   - keeps the most recent row (Y) address;
//   - for every column (X) word, writes one packed event {x, y, polarity} to
//     the FIFO through a request/grant port.
//
// Parameters:
//   X_BITS        column address width (default 9)
//   Y_BITS        row address width (default 9)
//   EVENT_BITS    must equal X_BITS + Y_BITS + 1
//   CLK_PERIOD_NS clock period, used only to derive the settle count
//   Y_SETTLE_NS   minimum time from REQ assertion to ACK
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  dvs_aer_to_event_iface_if.slave (aer, xsel, req, ack, fifo_req,
//        fifo_grant, fifo_wr_en, fifo_event)
//
// Configuration macro:
//   DVS_AER_SYNC3_EN  When defined, req goes through a 3-flop synchronizer
//                     instead of 2 flops. Every req-related latency grows by
//                     one cycle.
// -----------------------------------------------------------------------------
module dvs_aer_to_event_iface #(
    parameter int X_BITS        = 9,
    parameter int Y_BITS        = 9,
    parameter int EVENT_BITS    = 19,
    parameter int CLK_PERIOD_NS = 10,
    parameter int Y_SETTLE_NS   = 50
) (
    input  logic                      clk,
    input  logic                      rst,
    dvs_aer_to_event_iface_if.slave   bus
);

`ifdef DVS_AER_SYNC3_EN
    localparam int SYNC_STAGES = 3;
`else
    localparam int SYNC_STAGES = 2;
`endif

    localparam int Y_SETTLE_CYC = (Y_SETTLE_NS + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS;

    // The IDLE cycle that first observes req_s counts as the first settle
    // cycle. The SETTLE state therefore runs for Y_SETTLE_CYC-1 cycles. The
    // latency from req_s to ack is then Y_SETTLE_CYC settle cycles plus the
    // LATCH cycle.
    localparam int SETTLE_LAST = (Y_SETTLE_CYC >= 2) ? (Y_SETTLE_CYC - 2) : 0;
    localparam int CNT_W       = (Y_SETTLE_CYC > 2) ? $clog2(Y_SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST_C = CNT_W'(SETTLE_LAST);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LATCH  = 2'd2,
        ST_ACK    = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    req_s;
    logic                    ack_q, ack_d;
    logic [Y_BITS-1:0]       row_q, row_d;
    logic                    pend_q, pend_d;
    logic [EVENT_BITS-1:0]   pend_evt_q, pend_evt_d;
    logic                    wr_en_q, wr_en_d;
    logic [EVENT_BITS-1:0]   evt_q, evt_d;

    assign req_s = sync_q[SYNC_STAGES-1];

    // Next-state and datapath logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        row_d      = row_q;
        pend_d     = pend_q;
        pend_evt_d = pend_evt_q;
        wr_en_d    = 1'b0;
        evt_d      = evt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end
            end

            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST_C) begin
                    state_d = ST_LATCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_LATCH: begin
                // aer and xsel are held stable by the camera for the whole
                // time req is high. Sampling them here needs no synchronizer.
                if (!bus.xsel) begin
                    row_d   = bus.aer[Y_BITS-1:0];
                    state_d = ST_ACK;
                end else if (!pend_q) begin
                    pend_evt_d = {bus.aer[X_BITS:1], row_q, bus.aer[0]};
                    pend_d     = 1'b1;
                    state_d    = ST_ACK;
                end
                // An X word that arrives while a write is still pending waits
                // here with ack withheld. This stalls the camera instead of
                // dropping the event.
            end

            ST_ACK: begin
                if (!req_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ack_d = (state_d == ST_ACK);

        // FIFO write sequence. The first sampled grant fires a one-cycle
        // strobe. The following cycle retires the pending event, which drops
        // fifo_req. The LATCH condition and this clear are mutually exclusive
        // on pend_q, so the two never write pend_d in the same cycle.
        if (pend_q) begin
            if (wr_en_q) begin
                pend_d = 1'b0;
            end else if (bus.fifo_grant) begin
                wr_en_d = 1'b1;
                evt_d   = pend_evt_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ack_q      <= 1'b0;
            row_q      <= '0;
            pend_q     <= 1'b0;
            pend_evt_q <= '0;
            wr_en_q    <= 1'b0;
            evt_q      <= '0;
        end else begin
            if (SYNC_STAGES > 1) begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], bus.req};
            end
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            row_q      <= row_d;
            pend_q     <= pend_d;
            pend_evt_q <= pend_evt_d;
            wr_en_q    <= wr_en_d;
            evt_q      <= evt_d;
        end
    end

    assign bus.ack        = ack_q;
    assign bus.fifo_req   = pend_q;
    assign bus.fifo_wr_en = wr_en_q;
    assign bus.fifo_event = evt_q;

endmodule

// File: tb/tb_dvs_aer_to_event_iface.sv
module tb_dvs_aer_to_event_iface;
    localparam int XB = 9;
    localparam int YB = 9;
    localparam int EB = 19;

`ifdef DVS_AER_SYNC3_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    // Expected req->ack latency: 2 sync cycles + 5 settle cycles + 1 latch cycle.
    localparam int LAT_UP     = 8 + EXTRA;
    localparam int LAT_DN_MIN = 2;
    localparam int LAT_DN_MAX = 3 + EXTRA;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dvs_aer_to_event_iface_if #(.X_BITS(XB), .Y_BITS(YB), .EVENT_BITS(EB)) bus ();

    dvs_aer_to_event_iface #(
        .X_BITS(XB), .Y_BITS(YB), .EVENT_BITS(EB),
        .CLK_PERIOD_NS(10), .Y_SETTLE_NS(50)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Behavioural reference model. exp_q holds the events the camera has
    // produced. row_m is the row most recently sent.
    logic [EB-1:0] exp_q[$];
    logic [EB-1:0] got_q[$];
    logic [8:0]    row_m = 9'h000;

    // Arbiter model controls
    int gnt_delay = 0;
    bit rand_gnt  = 1'b0;
    int gnt_cyc   = -1;

    // Monitor bookkeeping
    int wr_wo_gnt    = 0;
    int wr_long      = 0;
    int req_drop_bad = 0;
    int last_wr_cyc  = -1;
    logic prev_req   = 1'b0;
    logic prev_wr    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Arbiter: grants after a programmed or random number of cycles and holds
    // the grant until fifo_req falls.
    initial begin
        int wait_n;
        int cur;
        wait_n = 0;
        cur    = 0;
        bus.fifo_grant = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (bus.fifo_req !== 1'b1) begin
                bus.fifo_grant = 1'b0;
                wait_n = 0;
                cur = rand_gnt ? int'($urandom_range(0, 6)) : gnt_delay;
            end else if (!bus.fifo_grant) begin
                if (wait_n >= cur) begin
                    bus.fifo_grant = 1'b1;
                    gnt_cyc = cyc;
                end else begin
                    wait_n++;
                end
            end
        end
    end

    // Write monitor: collects events and counts protocol violations
    always @(posedge clk) begin
        #2;
        if (bus.fifo_wr_en === 1'b1) begin
            got_q.push_back(bus.fifo_event);
            last_wr_cyc = cyc;
            if (bus.fifo_grant !== 1'b1) wr_wo_gnt++;
            if (prev_wr === 1'b1) wr_long++;
        end
        if (prev_req === 1'b1 && bus.fifo_req === 1'b0 && prev_wr !== 1'b1 && rst === 1'b0)
            req_drop_bad++;
        prev_req = bus.fifo_req;
        prev_wr  = bus.fifo_wr_en;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // One camera handshake. The model is updated as the word is presented.
    task automatic send_word(input bit is_x, input logic [9:0] word, input int hold,
                             output int lat_up, output int lat_dn, output bit dropped,
                             output longint t_up, output int up_cyc);
        longint t0;
        @(negedge clk);
        bus.aer  = word;
        bus.xsel = is_x;
        if (is_x) exp_q.push_back({word[9:1], row_m, word[0]});
        else      row_m = word[8:0];
        bus.req = 1'b1;
        t0      = $time;
        lat_up  = -1;
        lat_dn  = -1;
        dropped = 1'b0;
        t_up    = -1;
        up_cyc  = -1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (bus.ack === 1'b1) begin
                lat_up = i;
                t_up   = ($time - 5) - t0;
                up_cyc = cyc;
                break;
            end
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bus.ack !== 1'b1) dropped = 1'b1;
        end
        bus.req = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (bus.ack === 1'b0) begin
                lat_dn = i;
                break;
            end
        end
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (got_q.size() >= exp_q.size() && bus.fifo_req === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        int lat;
        rst = 1'b1;
        bus.req = 1'b1; bus.xsel = 1'b0; bus.aer = '0;
        row_m = 9'h000;
        repeat (2) @(negedge clk);
        checks++; if (bus.ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", bus.ack); end
        checks++; if (bus.fifo_req !== 1'b0) begin failures++; $display("FAIL reset_fifo_req got=%b exp=0", bus.fifo_req); end
        checks++; if (bus.fifo_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", bus.fifo_wr_en); end
        checks++; if (bus.fifo_event !== '0) begin failures++; $display("FAIL reset_event got=%h exp=0", bus.fifo_event); end
        rst = 1'b0;
        lat = -1;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (bus.ack === 1'b1) begin lat = i; break; end
        end
        checks++; if (lat != LAT_UP) begin failures++; $display("FAIL reset_release_latency got=%0d exp=%0d", lat, LAT_UP); end
        bus.req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.ack === 1'b0) break;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lu, ld, uc, lat;
        bit dr, ok;
        longint tu;
        gnt_delay = 0;
        send_word(1'b0, {1'b0, 9'h1FF}, 0, lu, ld, dr, tu, uc);
        gnt_delay = 1000;
        repeat (2) @(negedge clk);
        bus.aer = {9'h0AB, 1'b1}; bus.xsel = 1'b1; bus.req = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.ack === 1'b1) break;
        end
        checks++; if (bus.fifo_req !== 1'b1) begin failures++; $display("FAIL mid_pending_req got=%b exp=1", bus.fifo_req); end
        rst = 1'b1;
        gnt_delay = 0;
        @(negedge clk);
        checks++; if (bus.ack !== 1'b0) begin failures++; $display("FAIL mid_reset_ack got=%b exp=0", bus.ack); end
        checks++; if (bus.fifo_req !== 1'b0) begin failures++; $display("FAIL mid_reset_fifo_req got=%b exp=0", bus.fifo_req); end
        rst = 1'b0;
        // The discarded event is never written. The restarted handshake
        // re-latches the X word against the reset row (0).
        row_m = 9'h000;
        exp_q.push_back({9'h0AB, row_m, 1'b1});
        lat = -1;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (bus.ack === 1'b1) begin lat = i; break; end
        end
        checks++; if (lat != LAT_UP) begin failures++; $display("FAIL mid_restart_latency got=%0d exp=%0d", lat, LAT_UP); end
        bus.req = 1'b0;
        drain(ok);
        checks++; if (got_q.size() != 1) begin failures++; $display("FAIL mid_write_count got=%0d exp=1", got_q.size()); end
        checks++; if (got_q.size() < 1 || got_q[0] !== {9'h0AB, 9'h000, 1'b1}) begin
            failures++; $display("FAIL mid_event got=%h exp=%h", (got_q.size() > 0) ? got_q[0] : '0, {9'h0AB, 9'h000, 1'b1});
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_y_then_x();
        int lu, ld, uc;
        bit dr, ok;
        longint tu;
        gnt_delay = 0;
        send_word(1'b0, {1'b1, 9'h05A}, 0, lu, ld, dr, tu, uc);
        checks++; if (lu != LAT_UP) begin failures++; $display("FAIL yx_ack_latency got=%0d exp=%0d", lu, LAT_UP); end
        checks++; if (tu < 50) begin failures++; $display("FAIL yx_ack_time got=%0d exp>=50", tu); end
        checks++; if (ld < LAT_DN_MIN || ld > LAT_DN_MAX) begin failures++; $display("FAIL yx_ack_fall got=%0d exp=%0d..%0d", ld, LAT_DN_MIN, LAT_DN_MAX); end
        send_word(1'b1, {9'h123, 1'b1}, 0, lu, ld, dr, tu, uc);
        drain(ok);
        checks++; if (!ok) begin failures++; $display("FAIL yx_drain got=timeout exp=done"); end
        checks++; if (got_q.size() != 1) begin failures++; $display("FAIL yx_write_count got=%0d exp=1", got_q.size()); end
        checks++; if (got_q.size() < 1 || got_q[0] !== {9'h123, 9'h05A, 1'b1}) begin
            failures++; $display("FAIL yx_event got=%h exp=%h", (got_q.size() > 0) ? got_q[0] : '0, {9'h123, 9'h05A, 1'b1});
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_repeat_row();
        int lu, ld, uc;
        bit dr, ok;
        longint tu;
        gnt_delay = 0;
        send_word(1'b0, {1'b0, 9'h010}, 0, lu, ld, dr, tu, uc);
        send_word(1'b1, {9'h001, 1'b0}, 0, lu, ld, dr, tu, uc);
        send_word(1'b1, {9'h002, 1'b1}, 0, lu, ld, dr, tu, uc);
        drain(ok);
        checks++; if (got_q.size() != 2) begin failures++; $display("FAIL row_write_count got=%0d exp=2", got_q.size()); end
        checks++; if (got_q.size() < 1 || got_q[0] !== {9'h001, 9'h010, 1'b0}) begin
            failures++; $display("FAIL row_event0 got=%h exp=%h", (got_q.size() > 0) ? got_q[0] : '0, {9'h001, 9'h010, 1'b0});
        end
        checks++; if (got_q.size() < 2 || got_q[1] !== {9'h002, 9'h010, 1'b1}) begin
            failures++; $display("FAIL row_event1 got=%h exp=%h", (got_q.size() > 1) ? got_q[1] : '0, {9'h002, 9'h010, 1'b1});
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_grant_delay();
        int lu, ld, uc, wr1;
        bit dr, ok;
        longint tu;
        gnt_delay = 5;
        send_word(1'b1, {9'h0F0, 1'b0}, 0, lu, ld, dr, tu, uc);
        drain(ok);
        checks++; if (last_wr_cyc != gnt_cyc + 1) begin failures++; $display("FAIL gd_wr_after_grant got=%0d exp=%0d", last_wr_cyc, gnt_cyc + 1); end
        checks++; if (req_drop_bad != 0) begin failures++; $display("FAIL gd_req_held got=%0d exp=0", req_drop_bad); end
        checks++; if (got_q.size() != 1 || got_q[0] !== {9'h0F0, 9'h010, 1'b0}) begin
            failures++; $display("FAIL gd_event got=%h exp=%h", (got_q.size() > 0) ? got_q[0] : '0, {9'h0F0, 9'h010, 1'b0});
        end
        got_q.delete(); exp_q.delete();

        // The second X word arrives while the first write is still waiting
        // for grant.
        gnt_delay = 30;
        send_word(1'b1, {9'h111, 1'b1}, 0, lu, ld, dr, tu, uc);
        send_word(1'b1, {9'h122, 1'b0}, 0, lu, ld, dr, tu, uc);
        wr1 = last_wr_cyc;
        checks++; if (got_q.size() != 1) begin failures++; $display("FAIL gd_first_written got=%0d exp=1", got_q.size()); end
        checks++; if (uc <= wr1) begin failures++; $display("FAIL gd_ack_held got=%0d exp>%0d", uc, wr1); end
        checks++; if (lu <= LAT_UP) begin failures++; $display("FAIL gd_ack_latency got=%0d exp>%0d", lu, LAT_UP); end
        drain(ok);
        checks++; if (got_q.size() != 2) begin failures++; $display("FAIL gd_write_count got=%0d exp=2", got_q.size()); end
        for (int i = 0; i < 2 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL gd_event%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
        gnt_delay = 0;
    endtask

    task automatic test_slow_release();
        int lu, ld, uc;
        bit dr, ok;
        longint tu;
        gnt_delay = 0;
        send_word(1'b0, {1'b1, 9'h0C7}, 20, lu, ld, dr, tu, uc);
        checks++; if (dr) begin failures++; $display("FAIL slow_y_ack_held got=dropped exp=held"); end
        send_word(1'b1, {9'h1C3, 1'b1}, 20, lu, ld, dr, tu, uc);
        checks++; if (dr) begin failures++; $display("FAIL slow_x_ack_held got=dropped exp=held"); end
        checks++; if (ld < LAT_DN_MIN || ld > LAT_DN_MAX) begin failures++; $display("FAIL slow_ack_fall got=%0d exp=%0d..%0d", ld, LAT_DN_MIN, LAT_DN_MAX); end
        drain(ok);
        checks++; if (got_q.size() != 1) begin failures++; $display("FAIL slow_write_count got=%0d exp=1", got_q.size()); end
        checks++; if (got_q.size() < 1 || got_q[0] !== {9'h1C3, 9'h0C7, 1'b1}) begin
            failures++; $display("FAIL slow_event got=%h exp=%h", (got_q.size() > 0) ? got_q[0] : '0, {9'h1C3, 9'h0C7, 1'b1});
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        int lu, ld, uc, to_cnt, nx;
        bit dr, ok;
        longint tu;
        logic [9:0] w;
        rand_gnt = 1'b1;
        to_cnt = 0;
        nx = 0;
        for (int n = 0; n < 50; n++) begin
            w = 10'($urandom);
            if ($urandom_range(0, 2) != 0) nx++;
            send_word((nx > 0 && exp_q.size() < nx), w, int'($urandom_range(0, 4)), lu, ld, dr, tu, uc);
            if (lu < 0 || ld < 0) to_cnt++;
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        drain(ok);
        checks++; if (to_cnt != 0) begin failures++; $display("FAIL rnd_handshake_timeouts got=%0d exp=0", to_cnt); end
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rnd_write_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rnd_event%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
        rand_gnt = 1'b0;
    endtask

    task automatic test_fifo_rules();
        checks++; if (wr_wo_gnt != 0) begin failures++; $display("FAIL rule_wr_without_grant got=%0d exp=0", wr_wo_gnt); end
        checks++; if (wr_long != 0) begin failures++; $display("FAIL rule_wr_pulse_width got=%0d exp=0", wr_long); end
        checks++; if (req_drop_bad != 0) begin failures++; $display("FAIL rule_req_drop_without_write got=%0d exp=0", req_drop_bad); end
    endtask

    initial begin
        rst      = 1'b1;
        bus.req  = 1'b0;
        bus.xsel = 1'b0;
        bus.aer  = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_reset_mid();
        test_y_then_x();
        test_repeat_row();
        test_grant_delay();
        test_slow_release();
        test_random();
        test_fifo_rules();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
